lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Initiator (pipeline-side) port for the byte-addressed, little-endian 64-bit data memory.
- Accepts one load/store request from the MEM stage.
- Drives the memory's memAddr/writeData/memWrite/memRead pins.
- Performs size extraction and sign/zero extension on loads.
- The memory only writes full doublewords, so sub-doubleword stores are done as a read-modify-write (RMW) sequence.

Parameters:
- MEM_BYTES, 64, size of the data memory in bytes. Addresses must satisfy alignedBase+7 < MEM_BYTES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- reqValid  input  1  request present
- reqReady  output  1  port idle, can accept a request
- reqWrite  input  1  1=store, 0=load
- reqSize  input  2  0=byte, 1=half, 2=word, 3=double (funct3[1:0])
- reqUnsigned  input  1  loads only: zero-extend (funct3[2])
- reqAddr  input  64  byte address
- reqWdata  input  64  store data; low bytes used per reqSize
- respValid  output  1  one-cycle completion pulse
- respData  output  64  load result; 0 for stores and errors
- respErr  output  1  valid with respValid: misaligned or out-of-range request
- memAddr  output  64  memory byte address
- writeData  output  64  memory write data
- memWrite  output  1  memory write enable (memory writes on the rising edge)
- memRead  output  1  memory read enable (readData is combinational)
- readData  input  64  memory read data

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - reqReady=1; respValid=0; respErr=0.
  - respData=0, memAddr=0, writeData=0, memWrite=0, memRead=0.
  - All memory-side outputs are registered, so asserting reset mid-write drops memWrite before the next edge and the write is aborted.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- reqReady=1 only in IDLE. A request is accepted on a rising edge with reqValid&reqReady.
- The request is latched at acceptance. reqAddr, reqWdata and the other request inputs may change afterwards.
- Address split: base = addr & ~7; off = addr[2:0]; nbytes = 1<<reqSize.
- Error condition: off % nbytes != 0, or base+7 >= MEM_BYTES. On error:
  - IDLE goes to RESP with respErr=1 and respData=0.
  - memRead and memWrite stay 0 throughout.
- Load:
  - IDLE goes to LOAD.
  - In LOAD: memAddr=base, memRead=1. readData is captured at the end of the cycle, then state goes to RESP.
  - respData = bytes [off .. off+nbytes-1] of the captured doubleword.
  - Sign-extended from the top bit unless reqUnsigned=1. reqUnsigned is ignored when reqSize=3.
- Store, reqSize=3:
  - IDLE goes to STORE.
  - In STORE: memAddr=base, writeData=reqWdata, memWrite=1 for exactly one cycle, then state goes to RESP.
- Store, reqSize<3 (RMW):
  - IDLE goes to RMW_RD.
  - In RMW_RD: memAddr=base, memRead=1; the doubleword is captured.
  - State goes to RMW_WR: writeData = captured word with bytes [off .. off+nbytes-1] replaced by reqWdata[8*nbytes-1:0]; memWrite=1 for one cycle.
  - Then state goes to RESP.
- memRead and memWrite are never both 1. Both are 0 in IDLE and RESP.
- RESP:
  - respValid=1 for exactly one cycle, respData/respErr valid, then state returns to IDLE.
  - respData and respErr hold their values until the next RESP.
- Latency from the accepting edge to the cycle in which respValid=1:
  - load: 2 cycles
  - double store: 2 cycles
  - sub-doubleword store: 3 cycles
  - error: 1 cycle
- Back-to-back: a new request can be accepted on the edge ending the first IDLE cycle after RESP. Sustained throughput is 1 request per 3/3/4/2 cycles (load, double store, RMW store, error).
- reqValid seen outside IDLE is ignored; it is neither queued nor dropped silently. The requester must hold the request until reqReady=1.

Test Plan:
- Memory bytes 0..7 = 83 34 05 0F B3 84 9A 00:
  - ld @0 -> respData=0x009A84B30F053483, respErr=0, respValid 2 cycles after accept.
  - lb @0 -> 0xFFFFFFFFFFFFFF83.
  - lbu @0 -> 0x83.
  - lw @4 -> 0x00000000009A84B3.
  - lh @6 -> 0x000000000000009A.
- Bytes 8..15 = 93 84 14 00 23 38 95 0E; sb 0xAA @9 (RMW):
  - Check RMW_RD asserts memRead with memAddr=8.
  - Check RMW_WR asserts memWrite with writeData=0x0E9538230014AA93.
  - Then ld @8 returns 0x0E9538230014AA93.
  - respValid 3 cycles after accept.
- sd 0x1122334455667788 @16 then ld @16 -> 0x1122334455667788. Only one memWrite cycle occurs.
- Error cases: lw @6 (misaligned) and ld @64 (out of range):
  - respErr=1, respData=0, respValid 1 cycle after accept.
  - memRead=memWrite=0 throughout.
- Reset asserted during RMW_WR before the rising edge:
  - memWrite drops immediately; memory bytes 8..15 are unchanged; state is IDLE with reqReady=1.
  - After release, reqValid held high with lhu @2 is accepted and returns 0x0F05.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store initiator port for a 64-bit little-endian doubleword memory.
// Loads extract and extend a sub-field of one doubleword read; sub-doubleword
// stores run as read-modify-write because the memory writes full doublewords.

// One byte lane of the RMW merge: take the store byte where selected.
module lsu_byte_lane (
  input  logic       sel,
  input  logic [7:0] rbyte,
  input  logic [7:0] wbyte,
  output logic [7:0] mbyte
);
  assign mbyte = sel ? wbyte : rbyte;
endmodule

module lsu_mem_port #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [63:0] reqAddr,
  input  logic [63:0] reqWdata,
  output logic        respValid,
  output logic [63:0] respData,
  output logic        respErr,
  output logic [63:0] memAddr,
  output logic [63:0] writeData,
  output logic        memWrite,
  output logic        memRead,
  input  logic [63:0] readData
);
  localparam int NUM_LANES = 8;
  // Highest legal doubleword base: base+7 must stay below MEM_BYTES.
  localparam logic [63:0] BASE_MAX = 64'(MEM_BYTES - 8);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  // Only the fields still needed after acceptance are kept.
  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [2:0]  off;
    logic [63:0] wdata;
  } req_t;

  state_t state, next;
  req_t   req;

  logic [63:0] in_base;
  logic [2:0]  in_off;
  logic        in_mis, in_err, accept;

  logic [NUM_LANES-1:0]      lane_sel;
  logic [63:0]               wd_shift;
  logic [NUM_LANES-1:0][7:0] merged;

  assign in_base  = {reqAddr[63:3], 3'b000};
  assign in_off   = reqAddr[2:0];
  assign reqReady = (state == IDLE);
  assign accept   = reqValid & reqReady;

  // Misalignment: the offset must be a multiple of the access size.
  always_comb begin
    in_mis = 1'b0;
    case (reqSize)
      2'd0:    in_mis = 1'b0;
      2'd1:    in_mis = in_off[0];
      2'd2:    in_mis = |in_off[1:0];
      default: in_mis = |in_off;
    endcase
  end

  assign in_err = in_mis | (in_base > BASE_MAX);

  // Sub-field extraction of a loaded doubleword with sign/zero extension.
  function automatic logic [63:0] load_ext(input logic [63:0] rd, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] sh;
    sh = rd >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    load_ext = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    load_ext = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: load_ext = sh;
    endcase
  endfunction

  // Byte lanes touched by the latched store.
  always_comb begin
    lane_sel = '0;
    case (req.size)
      2'd0:    lane_sel = 8'h01 << req.off;
      2'd1:    lane_sel = 8'h03 << req.off;
      2'd2:    lane_sel = 8'h0F << req.off;
      default: lane_sel = 8'hFF;
    endcase
  end

  assign wd_shift = req.wdata << {req.off, 3'b000};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_byte_lane u_lane (
      .sel   (lane_sel[g]),
      .rbyte (readData[8*g +: 8]),
      .wbyte (wd_shift[8*g +: 8]),
      .mbyte (merged[g])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  // Next-state decode.
  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_err)             next = RESP;
          else if (!reqWrite)     next = LOAD;
          else if (reqSize == 3)  next = STORE;
          else                    next = RMW_RD;
        end
      end
      LOAD:    next = RESP;
      STORE:   next = RESP;
      RMW_RD:  next = RMW_WR;
      RMW_WR:  next = RESP;
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Latch the request at acceptance so the requester may move on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req <= '0;
    else if (accept) req <= '{size: reqSize, uns: reqUnsigned, off: in_off, wdata: reqWdata};
  end

  // Registered memory-side and response outputs, set for the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      memAddr   <= '0;
      writeData <= '0;
      memWrite  <= 1'b0;
      memRead   <= 1'b0;
      respValid <= 1'b0;
      respErr   <= 1'b0;
      respData  <= '0;
    end else begin
      memWrite  <= 1'b0;
      memRead   <= 1'b0;
      respValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (in_err) begin
              respValid <= 1'b1;
              respErr   <= 1'b1;
              respData  <= '0;
            end else begin
              memAddr <= in_base;
              if (reqWrite && reqSize == 2'd3) begin
                memWrite  <= 1'b1;
                writeData <= reqWdata;
              end else begin
                memRead <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          respValid <= 1'b1;
          respErr   <= 1'b0;
          respData  <= load_ext(readData, req.off, req.size, req.uns);
        end
        RMW_RD: begin
          memWrite  <= 1'b1;
          writeData <= merged;
        end
        STORE, RMW_WR: begin
          respValid <= 1'b1;
          respErr   <= 1'b0;
          respData  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port against a byte-array reference memory.
module tb_lsu_mem_port;
  localparam int MEM = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [63:0] reqAddr, reqWdata;
  logic        respValid, respErr;
  logic [63:0] respData, memAddr, writeData, readData;
  logic        memWrite, memRead;
  logic        load_img;

  logic [7:0] mem     [0:MEM-1];
  logic [7:0] ref_mem [0:MEM-1];

  int n_chk = 0;
  int n_fail = 0;

  lsu_mem_port #(.MEM_BYTES(MEM)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respData(respData), .respErr(respErr),
    .memAddr(memAddr), .writeData(writeData), .memWrite(memWrite), .memRead(memRead),
    .readData(readData)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, doubleword write on the rising edge.
  always_comb begin
    readData = '0;
    if (memAddr <= 64'(MEM - 8))
      for (int i = 0; i < 8; i++) readData[8*i +: 8] = mem[int'(memAddr[5:0]) + i];
  end

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < MEM; i++) mem[i] <= ref_mem[i];
    end else if (memWrite && memAddr <= 64'(MEM - 8)) begin
      for (int i = 0; i < 8; i++) mem[int'(memAddr[5:0]) + i] <= writeData[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mword(input int b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = mem[b + i];
    return r;
  endfunction

  function automatic logic [63:0] rword(input int b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[b + i];
    return r;
  endfunction

  // Issue one request (called at a falling edge) and check it against the model.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [63:0] a, input logic [63:0] wd, output logic [63:0] rdata);
    int nb, off, exp_lat, exp_nwr, exp_nrd, lat, nwr, nrd, guard;
    logic [63:0] base, exp_data, exp_wd, got_data;
    logic err, got, got_err;
    nb = 1 << sz;
    off = int'(a[2:0]);
    base = a & ~64'd7;
    err = (off % nb != 0) || (base + 64'd7 >= 64'(MEM));
    exp_data = '0;
    exp_wd = '0;
    if (!err) begin
      for (int i = 0; i < 8; i++) exp_wd[8*i +: 8] = ref_mem[int'(base) + i];
      if (!w) begin
        for (int i = 0; i < nb; i++) exp_data |= 64'(ref_mem[int'(a) + i]) << (8*i);
        if (!u && nb < 8 && exp_data[8*nb-1]) exp_data |= ~((64'd1 << (8*nb)) - 64'd1);
      end else begin
        for (int i = 0; i < nb; i++) exp_wd[8*(off+i) +: 8] = wd[8*i +: 8];
      end
    end
    exp_lat = err ? 1 : (!w ? 2 : (nb == 8 ? 2 : 3));
    exp_nwr = (!err && w) ? 1 : 0;
    exp_nrd = (!err && (!w || nb < 8)) ? 1 : 0;

    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqUnsigned = u; reqAddr = a; reqWdata = wd;
    guard = 0;
    while (!reqReady && guard < 20) begin @(negedge clk); guard++; end
    rdata = '0;
    if (!reqReady) begin
      chk("ready_timeout", 64'd0, 64'd1);
      reqValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    reqValid = 1'b0;
    reqAddr = {$urandom, $urandom}; reqWdata = {$urandom, $urandom};
    reqSize = 2'($urandom); reqWrite = 1'($urandom); reqUnsigned = 1'($urandom);

    lat = 0; nwr = 0; nrd = 0; got = 1'b0; got_err = 1'b0; got_data = '0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      chk("rd_wr_excl", 64'(memRead & memWrite), 64'd0);
      if (memRead)  begin nrd++; chk("rd_addr", memAddr, base); end
      if (memWrite) begin nwr++; chk("wr_addr", memAddr, base); chk("wr_data", writeData, exp_wd); end
      if (respValid) begin got = 1'b1; got_data = respData; got_err = respErr; end
    end
    if (!got) chk("resp_timeout", 64'd0, 64'd1);
    else begin
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("resp_err", 64'(got_err), 64'(err));
      chk("resp_data", got_data, exp_data);
    end
    chk("n_write", 64'(nwr), 64'(exp_nwr));
    chk("n_read", 64'(nrd), 64'(exp_nrd));
    if (!err && w) begin
      for (int i = 0; i < 8; i++) ref_mem[int'(base) + i] = exp_wd[8*i +: 8];
      chk("mem_after_store", mword(int'(base)), exp_wd);
    end
    rdata = got_data;
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] a;
    logic [7:0] img [0:15];
    img = '{8'h83, 8'h34, 8'h05, 8'h0F, 8'hB3, 8'h84, 8'h9A, 8'h00,
            8'h93, 8'h84, 8'h14, 8'h00, 8'h23, 8'h38, 8'h95, 8'h0E};
    reset = 1'b0; load_img = 1'b1;
    reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
    reqAddr = '0; reqWdata = '0;
    for (int i = 0; i < MEM; i++) ref_mem[i] = (i < 16) ? img[i] : 8'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_img = 1'b0;

    chk("rst_ready", 64'(reqReady), 64'd1);
    chk("rst_valid", 64'(respValid), 64'd0);
    chk("rst_err", 64'(respErr), 64'd0);
    chk("rst_data", respData, 64'd0);
    chk("rst_addr", memAddr, 64'd0);
    chk("rst_wdata", writeData, 64'd0);
    chk("rst_mwr", 64'(memWrite), 64'd0);
    chk("rst_mrd", 64'(memRead), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, d); chk("ld0", d, 64'h009A84B30F053483);
    do_req(1'b0, 2'd0, 1'b0, 64'd0, 64'd0, d); chk("lb0", d, 64'hFFFFFFFFFFFFFF83);
    do_req(1'b0, 2'd0, 1'b1, 64'd0, 64'd0, d); chk("lbu0", d, 64'h83);
    do_req(1'b0, 2'd2, 1'b0, 64'd4, 64'd0, d); chk("lw4", d, 64'h00000000009A84B3);
    do_req(1'b0, 2'd1, 1'b0, 64'd6, 64'd0, d); chk("lh6", d, 64'h9A);

    // Abort an RMW by asserting reset during its write cycle.
    @(negedge clk);
    chk("abort_ready", 64'(reqReady), 64'd1);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqUnsigned = 1'b0;
    reqAddr = 64'd9; reqWdata = 64'hAA;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(negedge clk);
    chk("abort_rd", 64'(memRead), 64'd1);
    chk("abort_rd_addr", memAddr, 64'd8);
    @(negedge clk);
    chk("abort_wr", 64'(memWrite), 64'd1);
    chk("abort_wr_data", writeData, 64'h0E9538230014AA93);
    #2 reset = 1'b0;
    #1;
    chk("abort_mwr_drop", 64'(memWrite), 64'd0);
    chk("abort_ready_rst", 64'(reqReady), 64'd1);
    @(negedge clk);
    chk("abort_mem_kept", mword(8), 64'h0E95382300148493);
    chk("abort_mem_ref", mword(8), rword(8));
    reset = 1'b1;
    do_req(1'b0, 2'd1, 1'b1, 64'd2, 64'd0, d); chk("lhu2", d, 64'h0F05);

    do_req(1'b1, 2'd0, 1'b0, 64'd9, 64'hAA, d);
    do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, d); chk("ld8", d, 64'h0E9538230014AA93);
    @(negedge clk);
    chk("resp_hold", respData, 64'h0E9538230014AA93);
    do_req(1'b1, 2'd3, 1'b0, 64'd16, 64'h1122334455667788, d);
    do_req(1'b0, 2'd3, 1'b0, 64'd16, 64'd0, d); chk("ld16", d, 64'h1122334455667788);
    do_req(1'b0, 2'd2, 1'b0, 64'd6, 64'd0, d);
    do_req(1'b0, 2'd3, 1'b0, 64'd64, 64'd0, d);

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 15) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 71));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom}, d);
    end

    for (int b = 0; b < MEM; b += 8) chk("final_mem", mword(b), rword(b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
